memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 122 ++++++++++++
 tb/tb_memory_access.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: M register, bus request FSM with
// timeout abort, and the writeback (W) register.
module memory_access (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] i_ALU_output_E,
    input  logic [31:0] i_wr_data_E,
    input  logic [4:0]  i_register_file_wr_addr_E,
    input  logic        i_register_file_wr_en_E,
    input  logic        i_data_memory_wr_en_E,
    input  logic        i_sel_result_E,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_ALU_output_M,
    output logic [4:0]  o_register_file_wr_addr_M,
    output logic        o_register_file_wr_en_M,
    output logic        o_stall_M,
    output logic [31:0] o_result_W,
    output logic [4:0]  o_register_file_wr_addr_W,
    output logic        o_register_file_wr_en_W,
    output logic        o_mem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        abort;
    logic        mem_op;

    logic [31:0] alu_m;
    logic [31:0] wd_m;
    logic [4:0]  rd_m;
    logic        we_m;
    logic        dm_m;
    logic        sel_m;

    assign mem_op      = dm_m | sel_m;
    assign o_mem_req   = mem_op;
    assign o_mem_we    = dm_m;
    assign o_mem_addr  = alu_m;
    assign o_mem_wdata = wd_m;
    assign o_stall_M   = mem_op & ~i_mem_ack & ~abort;

    assign o_ALU_output_M            = alu_m;
    assign o_register_file_wr_addr_M = rd_m;
    assign o_register_file_wr_en_M   = we_m;

    // Next-state and abort decode for the outstanding bus access.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mem_op && !i_mem_ack)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                abort = (cnt == 4'd15) && !i_mem_ack;
                if (i_mem_ack || abort)
                    state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            o_mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE)
                cnt <= 4'd0;
            else if (!i_mem_ack)
                cnt <= cnt + 4'd1;
            if (abort)
                o_mem_err <= 1'b1;
        end
    end

    // M register: capture execute outputs unless the stage is stalled.
    always_ff @(posedge clk) begin
        if (clr) begin
            alu_m <= 32'd0;
            wd_m  <= 32'd0;
            rd_m  <= 5'd0;
            we_m  <= 1'b0;
            dm_m  <= 1'b0;
            sel_m <= 1'b0;
        end else if (!o_stall_M) begin
            alu_m <= i_ALU_output_E;
            wd_m  <= i_wr_data_E;
            rd_m  <= i_register_file_wr_addr_E;
            we_m  <= i_register_file_wr_en_E;
            dm_m  <= i_data_memory_wr_en_E;
            sel_m <= i_sel_result_E;
        end
    end

    // W register: retire the M instruction, or insert a bubble on stall.
    always_ff @(posedge clk) begin
        if (clr) begin
            o_result_W                <= 32'd0;
            o_register_file_wr_addr_W <= 5'd0;
            o_register_file_wr_en_W   <= 1'b0;
        end else if (o_stall_M) begin
            o_register_file_wr_en_W <= 1'b0;
        end else begin
            o_result_W                <= sel_m ? i_mem_rdata : alu_m;
            o_register_file_wr_addr_W <= rd_m;
            o_register_file_wr_en_W   <= we_m & ~abort;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vector table, hand-written
// timeout/reset sequences, then random traffic against a model.
module tb_memory_access;

    logic        clk;
    logic        clr;
    logic [31:0] alu_e;
    logic [31:0] wd_e;
    logic [4:0]  rd_e;
    logic        we_e;
    logic        dm_e;
    logic        sel_e;
    logic        req;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] alu_m;
    logic [4:0]  rd_m;
    logic        we_m;
    logic        stall;
    logic [31:0] res_w;
    logic [4:0]  rd_w;
    logic        we_w;
    logic        err;

    int total = 0;
    int bad   = 0;

    memory_access dut (
        .clk                       (clk),
        .clr                       (clr),
        .i_ALU_output_E            (alu_e),
        .i_wr_data_E               (wd_e),
        .i_register_file_wr_addr_E (rd_e),
        .i_register_file_wr_en_E   (we_e),
        .i_data_memory_wr_en_E     (dm_e),
        .i_sel_result_E            (sel_e),
        .o_mem_req                 (req),
        .o_mem_we                  (mwe),
        .o_mem_addr                (maddr),
        .o_mem_wdata               (mwdata),
        .i_mem_ack                 (ack),
        .i_mem_rdata               (rdata),
        .o_ALU_output_M            (alu_m),
        .o_register_file_wr_addr_M (rd_m),
        .o_register_file_wr_en_M   (we_m),
        .o_stall_M                 (stall),
        .o_result_W                (res_w),
        .o_register_file_wr_addr_W (rd_w),
        .o_register_file_wr_en_W   (we_w),
        .o_mem_err                 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        we;
        logic        dm;
        logic        sel;
        logic        ack;
        logic [31:0] rdata;
        logic        x_req;
        logic        x_stall;
        logic        x_we;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic [31:0] x_res;
        logic [4:0]  x_wa;
        logic        x_wen;
    } row_t;

    row_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] w,
                         input logic [4:0] r, input logic e,
                         input logic d, input logic s);
        alu_e = a;
        wd_e  = w;
        rd_e  = r;
        we_e  = e;
        dm_e  = d;
        sel_e = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t mk(
        input logic [31:0] a, input logic [31:0] w, input logic [4:0] r,
        input logic e, input logic d, input logic s, input logic k,
        input logic [31:0] rd_v, input logic xq, input logic xs,
        input logic xw, input logic [31:0] xa, input logic [31:0] xd,
        input logic [31:0] xr, input logic [4:0] xwa, input logic xe);
        row_t t;
        t.alu = a; t.wd = w; t.rd = r; t.we = e; t.dm = d; t.sel = s;
        t.ack = k; t.rdata = rd_v;
        t.x_req = xq; t.x_stall = xs; t.x_we = xw;
        t.x_addr = xa; t.x_wdata = xd;
        t.x_res = xr; t.x_wa = xwa; t.x_wen = xe;
        return t;
    endfunction

    // reference model state (instruction-level view)
    logic [31:0] m_alu, m_wd, m_res;
    logic [4:0]  m_rd, m_wa;
    logic        m_we, m_dm, m_sel, m_wen, m_err;
    int          waited;

    initial begin
        int stalls;
        logic        p_req, p_abort, p_stall;
        logic        k;
        int          kind;

        clr = 1'b1;
        ack = 1'b0;
        rdata = 32'd0;
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_res_w", res_w, 32'd0);
        chk("rst_wen_w", {31'd0, we_w}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        clr = 1'b0;

        // ALU op, zero-wait load, 3-wait store, back-to-back 1-wait loads
        tbl[0]  = mk(32'h1234, 0, 5, 1, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 32'h1234, 5, 1);
        tbl[2]  = mk(32'h40, 0, 7, 1, 0, 1, 0, 0,
                     0, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                     1, 0, 0, 32'h40, 0, 32'hDEADBEEF, 7, 1);
        tbl[4]  = mk(32'h80, 32'hA5A5A5A5, 0, 0, 1, 0, 0, 0,
                     0, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[5]  = mk(32'h55, 0, 3, 1, 0, 0, 0, 0,
                     1, 1, 1, 32'h80, 32'hA5A5A5A5, 32'h0, 0, 0);
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = mk(32'h55, 0, 3, 1, 0, 0, 1, 0,
                     1, 0, 1, 32'h80, 32'hA5A5A5A5, 32'h80, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 32'h55, 3, 1);
        tbl[10] = mk(32'h100, 0, 1, 1, 0, 1, 0, 0,
                     0, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[11] = mk(32'h104, 0, 2, 1, 0, 1, 0, 0,
                     1, 1, 0, 32'h100, 0, 32'h0, 0, 0);
        tbl[12] = mk(32'h104, 0, 2, 1, 0, 1, 1, 32'h11111111,
                     1, 0, 0, 32'h100, 0, 32'h11111111, 1, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                     1, 1, 0, 32'h104, 0, 32'h11111111, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 32'h22222222,
                     1, 0, 0, 32'h104, 0, 32'h22222222, 2, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 32'h0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].alu, tbl[i].wd, tbl[i].rd,
                  tbl[i].we, tbl[i].dm, tbl[i].sel);
            ack   = tbl[i].ack;
            rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, req},
                {31'd0, tbl[i].x_req});
            chk($sformatf("v%0d_stall", i), {31'd0, stall},
                {31'd0, tbl[i].x_stall});
            if (tbl[i].x_req) begin
                chk($sformatf("v%0d_we", i), {31'd0, mwe},
                    {31'd0, tbl[i].x_we});
                chk($sformatf("v%0d_addr", i), maddr, tbl[i].x_addr);
                chk($sformatf("v%0d_wdata", i), mwdata,
                    tbl[i].x_wdata);
            end
            step();
            chk($sformatf("v%0d_res_w", i), res_w, tbl[i].x_res);
            chk($sformatf("v%0d_wa_w", i), {27'd0, rd_w},
                {27'd0, tbl[i].x_wa});
            chk($sformatf("v%0d_wen_w", i), {31'd0, we_w},
                {31'd0, tbl[i].x_wen});
        end

        // load that never gets an ack: 16 stalls then abort
        drive(32'h200, 0, 9, 1, 0, 1);
        ack = 1'b0;
        step();
        drive(0, 0, 0, 0, 0, 0);
        stalls = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            step();
        end
        chk("to_stalls", stalls, 16);
        chk("to_req_abort_cyc", {31'd0, req}, 32'd1);
        step();
        chk("to_wen_w", {31'd0, we_w}, 32'd0);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_req_after", {31'd0, req}, 32'd0);
        ack = 1'b1;
        drive(32'h77, 0, 4, 1, 0, 0);
        step();
        ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("to_resume_res", res_w, 32'h77);
        chk("to_resume_wen", {31'd0, we_w}, 32'd1);
        chk("to_err_sticky", {31'd0, err}, 32'd1);

        // clr during the second WAIT cycle
        drive(32'h300, 0, 6, 1, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        clr = 1'b1;
        @(negedge clk);
        chk("clr_pre_stall", {31'd0, stall}, 32'd1);
        step();
        clr = 1'b0;
        chk("clr_req", {31'd0, req}, 32'd0);
        chk("clr_stall", {31'd0, stall}, 32'd0);
        chk("clr_res_w", res_w, 32'd0);
        chk("clr_wa_w", {27'd0, rd_w}, 32'd0);
        chk("clr_wen_w", {31'd0, we_w}, 32'd0);
        chk("clr_err", {31'd0, err}, 32'd0);

        // random traffic against the instruction-level model
        m_alu = 0; m_wd = 0; m_rd = 0; m_we = 0; m_dm = 0; m_sel = 0;
        m_res = 0; m_wa = 0; m_wen = 0; m_err = 0; waited = 0;
        for (int c = 0; c < 3000; c++) begin
            kind = int'($urandom_range(0, 3));
            drive($urandom, $urandom, 5'($urandom), 1'($urandom),
                  kind >= 2, kind == 1 || kind == 3);
            if (c < 2000) k = ($urandom_range(0, 2) == 0);
            else          k = ($urandom_range(0, 39) == 0);
            ack   = k;
            rdata = $urandom;
            clr   = ($urandom_range(0, 299) == 0);
            p_req   = m_dm | m_sel;
            p_abort = p_req && !k && waited == 16;
            p_stall = p_req && !k && !p_abort;
            @(negedge clk);
            chk("r_req", {31'd0, req}, {31'd0, p_req});
            chk("r_stall", {31'd0, stall}, {31'd0, p_stall});
            if (p_req) begin
                chk("r_we", {31'd0, mwe}, {31'd0, m_dm});
                chk("r_addr", maddr, m_alu);
                chk("r_wdata", mwdata, m_wd);
            end
            chk("r_alu_m", alu_m, m_alu);
            step();
            if (clr) begin
                m_alu = 0; m_wd = 0; m_rd = 0;
                m_we = 0; m_dm = 0; m_sel = 0;
                m_res = 0; m_wa = 0; m_wen = 0;
                m_err = 0; waited = 0;
            end else if (p_stall) begin
                waited++;
                m_wen = 1'b0;
            end else begin
                m_res = m_sel ? rdata : m_alu;
                m_wa  = m_rd;
                m_wen = m_we & !p_abort;
                if (p_abort) m_err = 1'b1;
                m_alu = alu_e; m_wd = wd_e; m_rd = rd_e;
                m_we = we_e; m_dm = dm_e; m_sel = sel_e;
                waited = 0;
            end
            chk("r_res_w", res_w, m_res);
            chk("r_wa_w", {27'd0, rd_w}, {27'd0, m_wa});
            chk("r_wen_w", {31'd0, we_w}, {31'd0, m_wen});
            chk("r_err", {31'd0, err}, {31'd0, m_err});
        end
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
